// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank.
//   - default parameter values for channel count, prescaler width and phase width
//   - channel mode encoding
//   - led_eval: output level of one channel for a given mode
package led_pwm_pkg;

  localparam int NCH_DEF = 4;
  localparam int PW_DEF  = 26;
  localparam int DW_DEF  = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_e;

  // blink_bit is the phase MSB, pwm_hit is (phase < duty).
  function automatic logic led_eval(input led_mode_e mode,
                                    input logic      blink_bit,
                                    input logic      pwm_hit);
    logic level;
    case (mode)
      MODE_OFF:   level = 1'b0;
      MODE_ON:    level = 1'b1;
      MODE_BLINK: level = blink_bit;
      MODE_PWM:   level = pwm_hit;
      default:    level = 1'b0;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..limit while en is high, then returns to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance enable
//   limit      : last count value before wrapping
//   q          : current count
//   wrap       : combinational, high in the cycle whose edge returns q to 0
// A limit lowered below the current count wraps on the next enabled edge.
module mod_counter
  import led_pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_r;
  logic             at_limit_s;

  assign at_limit_s = (cnt_r >= limit);
  assign wrap       = en & at_limit_s;
  assign q          = cnt_r;

  // Count register: advance or wrap when enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (en) begin
      if (at_limit_s) begin
        cnt_r <= {WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of NCH LED channels driven from a shared prescaler and phase counter.
// Ports:
//   CLK, RESETN : clock, asynchronous active-low reset
//   EN          : 1 = prescaler/phase run, 0 = hold (config becomes transparent)
//   DIV         : prescaler divisor, one tick every DIV+1 enabled cycles
//   MODE        : 2 bits per channel (OFF/ON/BLINK/PWM), ch i at [2i+1:2i]
//   DUTY        : DW bits per channel, ch i at [DW*i+DW-1:DW*i]
//   LED         : registered channel outputs
//   TICK, WRAP  : registered one-cycle pulses for prescaler / phase wrap
//   PHASE       : current phase count
// MODE/DUTY are copied into shadow registers only at a phase wrap while
// running, so a PWM period never mixes two configurations.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PW  = PW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              EN,
  input  logic [PW-1:0]     DIV,
  input  logic [2*NCH-1:0]  MODE,
  input  logic [DW*NCH-1:0] DUTY,
  output logic [NCH-1:0]    LED,
  output logic              TICK,
  output logic              WRAP,
  output logic [DW-1:0]     PHASE
);

  logic              tick_s;
  logic              wrap_s;
  logic [PW-1:0]     pre_q_unused_s;
  logic [DW-1:0]     phase_s;
  logic [2*NCH-1:0]  mode_sh_r;
  logic [DW*NCH-1:0] duty_sh_r;
  logic [NCH-1:0]    led_next_s;
  logic [NCH-1:0]    led_r;
  logic              tick_r;
  logic              wrap_r;

  mod_counter #(.WIDTH(PW)) u_prescaler (
    .clk   (CLK),
    .rst_n (RESETN),
    .en    (EN),
    .limit (DIV),
    .q     (pre_q_unused_s),
    .wrap  (tick_s)
  );

  // tick_s is already gated by EN, so the phase holds whenever EN is low.
  mod_counter #(.WIDTH(DW)) u_phase (
    .clk   (CLK),
    .rst_n (RESETN),
    .en    (tick_s),
    .limit ({DW{1'b1}}),
    .q     (phase_s),
    .wrap  (wrap_s)
  );

  // Shadow config: load at the period boundary, or continuously while held.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mode_sh_r <= {(2*NCH){1'b0}};
      duty_sh_r <= {(DW*NCH){1'b0}};
    end else if (wrap_s || !EN) begin
      mode_sh_r <= MODE;
      duty_sh_r <= DUTY;
    end else begin
      mode_sh_r <= mode_sh_r;
      duty_sh_r <= duty_sh_r;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign led_next_s[i] = led_eval(led_mode_e'(mode_sh_r[2*i +: 2]),
                                    phase_s[DW-1],
                                    (phase_s < duty_sh_r[DW*i +: DW]));
  end

  // Output registers: LED from current phase/shadow, pulses delayed one cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      led_r  <= {NCH{1'b0}};
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      led_r  <= led_next_s;
      tick_r <= tick_s;
      wrap_r <= wrap_s;
    end
  end

  assign LED   = led_r;
  assign TICK  = tick_r;
  assign WRAP  = wrap_r;
  assign PHASE = phase_s;

endmodule
